// File: rtl/ifns_pkg.sv
// Shared IFNS constants: code/data widths, Fibonacci wire weights, max legal value.
// Used by both the encoder and decoder sides of the link.
package ifns_pkg;
  localparam int IFNS_CODE_W = 7;
  localparam int IFNS_DATA_W = 5;
  localparam int IFNS_SUM_W  = 6;

  localparam logic [IFNS_SUM_W-1:0] F1 = 6'd1;
  localparam logic [IFNS_SUM_W-1:0] F2 = 6'd1;
  localparam logic [IFNS_SUM_W-1:0] F3 = 6'd2;
  localparam logic [IFNS_SUM_W-1:0] F4 = 6'd3;
  localparam logic [IFNS_SUM_W-1:0] F5 = 6'd5;
  localparam logic [IFNS_SUM_W-1:0] F6 = 6'd8;
  localparam logic [IFNS_SUM_W-1:0] F7 = 6'd13;

  localparam logic [IFNS_SUM_W-1:0] IFNS_MAX_VAL = 6'd31;

  typedef struct packed {
    logic [IFNS_DATA_W-1:0] data;
    logic                   err;
  } ifns_res_t;
endpackage

// File: rtl/decoderIFNS_7di_core.sv
// Combinational IFNS decode: Fibonacci-weighted sum of wires d7..d1.
// Structured to mirror the encoder core for back-to-back equivalence checks.
module decoderIFNS_7di_core
  import ifns_pkg::*;
(
  input  logic [IFNS_CODE_W:1]   d,
  output logic [IFNS_DATA_W-1:0] v,
  output logic                   illegal
);
  logic [IFNS_SUM_W-1:0] sum;

  always_comb begin
    sum = (d[1] ? F1 : '0) + (d[2] ? F2 : '0) + (d[3] ? F3 : '0) +
          (d[4] ? F4 : '0) + (d[5] ? F5 : '0) + (d[6] ? F6 : '0) +
          (d[7] ? F7 : '0);
  end

  assign v       = sum[IFNS_DATA_W-1:0];
  assign illegal = (sum > IFNS_MAX_VAL);
endmodule

// File: rtl/ifns_decoder_7.sv
// 2-stage registered IFNS 7-wire -> 5-bit decoder with range-error flag.
// Optional saturating illegal-word counter enabled by IFNS_DEC_ERRCNT_EN.
module ifns_decoder_7
  import ifns_pkg::*;
(
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [IFNS_CODE_W:1]   codein,
  input  logic                   valid_in,
  output logic [IFNS_DATA_W-1:0] dataout,
  output logic                   valid_out,
  output logic                   err
`ifdef IFNS_DEC_ERRCNT_EN
  ,output logic [7:0]            err_count
`endif
);
  logic [IFNS_CODE_W:1]   code_q;
  logic [1:0]             vld_pipe_q;
  logic [IFNS_DATA_W-1:0] core_v;
  logic                   core_ill;
  ifns_res_t              res_d, res_q;

  decoderIFNS_7di_core u_core (
    .d       (code_q),
    .v       (core_v),
    .illegal (core_ill)
  );

  // dataout only advances on valid words; bubbles hold the last result
  always_comb begin
    res_d = res_q;
    res_d.err = 1'b0;
    if (vld_pipe_q[0]) begin
      res_d.data = core_ill ? '0 : core_v;
      res_d.err  = core_ill;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      code_q     <= '0;
      vld_pipe_q <= '0;
      res_q      <= '0;
    end else begin
      code_q     <= codein;
      vld_pipe_q <= {vld_pipe_q[0], valid_in};
      res_q      <= res_d;
    end
  end

  assign dataout   = res_q.data;
  assign err       = res_q.err;
  assign valid_out = vld_pipe_q[1];

`ifdef IFNS_DEC_ERRCNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                                  cnt_q <= '0;
    else if (res_d.err && (cnt_q != 8'hFF))      cnt_q <= cnt_q + 8'd1;
  end

  assign err_count = cnt_q;
`endif
endmodule

// File: tb/tb_ifns_decoder_7.sv
// Self-checking bench for ifns_decoder_7: per-cycle model compare plus directed literal checks.
module tb_ifns_decoder_7;
  localparam int HN = 8192;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [7:1] codein;
  logic       valid_in;
  logic [4:0] dataout;
  logic       valid_out;
  logic       err;
`ifdef IFNS_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int failures = 0;

  ifns_decoder_7 dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .codein    (codein),
    .valid_in  (valid_in),
    .dataout   (dataout),
    .valid_out (valid_out),
    .err       (err)
`ifdef IFNS_DEC_ERRCNT_EN
    ,.err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plain Fibonacci-weighted value of a codeword.
  function automatic int wsum(input logic [7:1] c);
    int w[8];
    int s;
    w = '{0, 1, 1, 2, 3, 5, 8, 13};
    s = 0;
    for (int k = 1; k <= 7; k++) if (c[k]) s += w[k];
    return s;
  endfunction

  // Greedy Fibonacci encoder used for the loopback test.
  function automatic logic [7:1] enc(input int d);
    int w[8];
    int r;
    logic [7:1] c;
    w = '{0, 1, 1, 2, 3, 5, 8, 13};
    r = d;
    c = '0;
    for (int k = 7; k >= 1; k--) if (r >= w[k]) begin c[k] = 1'b1; r -= w[k]; end
    return c;
  endfunction

  // History of what stage 1 captured on each edge, and the output model.
  logic       hv [HN];
  logic [7:1] hc [HN];
  int         cyc = 0;
  int         exp_data = 0;
  int         exp_cnt = 0;

  always @(posedge clock) begin
    hv[cyc % HN] = rst_n ? valid_in : 1'b0;
    hc[cyc % HN] = codein;
    cyc++;
  end

  always @(negedge rst_n) begin
    if (cyc >= 1) hv[(cyc-1) % HN] = 1'b0;
    if (cyc >= 2) hv[(cyc-2) % HN] = 1'b0;
    exp_data = 0;
    exp_cnt  = 0;
  end

  always @(negedge clock) begin
    if (rst_n && cyc >= 2) begin
      int  s;
      logic ev, ee;
      ev = hv[(cyc-2) % HN];
      ee = 1'b0;
      if (ev) begin
        s  = wsum(hc[(cyc-2) % HN]);
        ee = (s > 31);
        exp_data = ee ? 0 : s;
        if (ee && exp_cnt < 255) exp_cnt++;
      end
      chk("m_valid_out", int'(valid_out), int'(ev));
      chk("m_dataout", int'(dataout), exp_data);
      chk("m_err", int'(err), int'(ee));
`ifdef IFNS_DEC_ERRCNT_EN
      chk("m_err_count", int'(err_count), exp_cnt);
`endif
    end
  end

  // Drive one valid word then a bubble; check the literal result 2 edges later.
  task automatic send_chk(input string name, input logic [7:1] c, input int ed, input int ee);
    codein = c; valid_in = 1'b1;
    @(negedge clock);
    valid_in = 1'b0; codein = 7'h55;
    @(negedge clock);
    chk({name, "_vo"}, int'(valid_out), 1);
    chk({name, "_data"}, int'(dataout), ed);
    chk({name, "_err"}, int'(err), ee);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; codein = '0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("post_reset_vo", int'(valid_out), 0);
    chk("post_reset_data", int'(dataout), 0);

    // Directed literals
    send_chk("lat_13", 7'b1000000, 13, 0);
    send_chk("mid_12", 7'b0101001, 12, 0);
    send_chk("mid_2", 7'b0000011, 2, 0);
    send_chk("ill_33", 7'b1111111, 0, 1);
    send_chk("ill_32", 7'b1111110, 0, 1);
    @(negedge clock);
    chk("bubble_vo", int'(valid_out), 0);
    chk("bubble_err", int'(err), 0);
    chk("bubble_hold", int'(dataout), 0);

    // Exhaustive stream with random bubbles
    for (int i = 0; i < 128; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        valid_in = 1'b0; codein = 7'($urandom);
        @(negedge clock);
      end
      valid_in = 1'b1; codein = 7'(i);
      @(negedge clock);
    end
    valid_in = 1'b0;
    repeat (3) @(negedge clock);

    // Encoder -> decoder loopback
    for (int d = 0; d < 32; d++) send_chk("loop", enc(d), d, 0);

    // Mid-stream reset with words in flight
    valid_in = 1'b1; codein = 7'b1111111;
    @(negedge clock);
    codein = 7'b1000000;
    repeat (3) @(negedge clock);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_vo", int'(valid_out), 0);
    chk("rst_data", int'(dataout), 0);
    chk("rst_err", int'(err), 0);
`ifdef IFNS_DEC_ERRCNT_EN
    chk("rst_cnt", int'(err_count), 0);
`endif
    valid_in = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("rst_idle_vo", int'(valid_out), 0);
    end
    codein = 7'b0000100; valid_in = 1'b1;
    @(negedge clock);
    valid_in = 1'b0;
    chk("rst_first_vo_early", int'(valid_out), 0);
    @(negedge clock);
    chk("rst_first_vo", int'(valid_out), 1);
    chk("rst_first_data", int'(dataout), 2);

`ifdef IFNS_DEC_ERRCNT_EN
    // Saturation: 300 illegal words mixed with legal words and bubbles
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    send_chk("cnt_one", 7'b1111110, 0, 1);
    chk("cnt_one_val", int'(err_count), 1);
    for (int i = 0; i < 299; i++) begin
      valid_in = 1'b1; codein = (i % 2) ? 7'b1111111 : 7'b1111110;
      @(negedge clock);
      if (i % 7 == 0) begin codein = 7'b0010101; @(negedge clock); end
      if (i % 5 == 0) begin valid_in = 1'b0; codein = 7'b1111111; @(negedge clock); end
    end
    valid_in = 1'b1; codein = 7'b0000001;
    repeat (4) @(negedge clock);
    valid_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("cnt_sat", int'(err_count), 255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
